bubble_page_reader: RTL and testbench

//  Host-side counterpart of the bubble emulator output path: drives nBSS/nBSEN/nREPEN/nBOOTEN

---
 rtl/bubble_page_reader.sv | 264 ++++++++++++++++++++++++++
 tb/tb_bubble_page_reader.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bubble_page_reader.sv
// bubble_page_reader
//   Host-side page reader for a bubble cartridge (real or emulated). Sequences
//   nBSS/nBSEN and nREPEN or nBOOTEN for one page access. It samples the DOUT0/DOUT1
//   pair once per bit slot and packs the samples LSB-first into bytes. Each byte is
//   handed out through a single holding register with a valid/ready handshake.
//
// Parameters
//   BITCYCLES   MCLK cycles per bubble bit slot
//   SAMPLEPOINT slot-counter value at which the synchronised DOUT pair is captured
//   PAGEBITS    bit slots per page access (multiple of 4)
//   BSS_LEAD    MCLK cycles nBSS leads/trails nBSEN
//
// Ports
//   MCLK, nRESET              clock (rising edge), asynchronous active-low reset
//   START, MODE, ABORT        request pulse, 0=normal / 1=bootloop, terminate access
//   nBSS, nBSEN               shift start / shift enable, active low, registered
//   nREPEN, nBOOTEN           replicate / bootloop enable, active low, registered
//   DOUT0, DOUT1              asynchronous bubble data lines
//   BYTE, BYTEVALID, BYTEREADY  output byte and its handshake
//   BUSY, DONE, OVERRUN       not idle, completion pulse, sticky dropped-byte flag
module bubble_page_reader #(
  parameter int BITCYCLES   = 480,
  parameter int SAMPLEPOINT = 240,
  parameter int PAGEBITS    = 512,
  parameter int BSS_LEAD    = 48
) (
  input  logic       MCLK,
  input  logic       nRESET,
  input  logic       START,
  input  logic       MODE,
  input  logic       ABORT,
  output logic       nBSS,
  output logic       nBSEN,
  output logic       nREPEN,
  output logic       nBOOTEN,
  input  logic       DOUT0,
  input  logic       DOUT1,
  output logic [7:0] BYTE,
  output logic       BYTEVALID,
  input  logic       BYTEREADY,
  output logic       BUSY,
  output logic       DONE,
  output logic       OVERRUN
);

  localparam int SW = (BITCYCLES > 1) ? $clog2(BITCYCLES) : 1;
  localparam int PW = (PAGEBITS  > 1) ? $clog2(PAGEBITS)  : 1;
  localparam int LW = (BSS_LEAD  > 1) ? $clog2(BSS_LEAD)  : 1;

  localparam logic [SW-1:0] SLOT_LAST   = SW'(BITCYCLES - 1);
  localparam logic [SW-1:0] SLOT_SAMPLE = SW'(SAMPLEPOINT);
  localparam logic [PW-1:0] BITS_LAST   = PW'(PAGEBITS - 1);
  localparam logic [LW-1:0] LEAD_LAST   = LW'(BSS_LEAD - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_STREAM,
    S_TAIL
  } state_e;

  state_e          state_q, state_d;
  logic            mode_q, mode_d;
  logic [LW-1:0]   lead_q, lead_d;
  logic [SW-1:0]   slot_q, slot_d;
  logic [PW-1:0]   bits_q, bits_d;
  logic [1:0]      k_q, k_d;
  logic [5:0]      asm_q, asm_d;
  logic            cmp_q, cmp_d;
  logic [7:0]      cmpbyte_q, cmpbyte_d;
  logic [1:0]      sync1_q, sync2_q;

  logic            nbss_q, nbss_d;
  logic            nbsen_q, nbsen_d;
  logic            nrepen_q, nrepen_d;
  logic            nbooten_q, nbooten_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [7:0]      byte_q, byte_d;
  logic            valid_q, valid_d;
  logic            ovr_q, ovr_d;
  logic            clr_ovr;
  logic            active;

  // Sequencer, sample counter and byte assembly.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    lead_d    = lead_q;
    slot_d    = slot_q;
    bits_d    = bits_q;
    k_d       = k_q;
    asm_d     = asm_q;
    cmp_d     = 1'b0;
    cmpbyte_d = cmpbyte_q;
    done_d    = 1'b0;
    clr_ovr   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (START && !ABORT) begin
          state_d = S_SETUP;
          mode_d  = MODE;
          clr_ovr = 1'b1;
          lead_d  = '0;
          slot_d  = '0;
          bits_d  = '0;
          k_d     = '0;
          asm_d   = '0;
        end
      end
      S_SETUP: begin
        if (lead_q == LEAD_LAST) begin
          state_d = S_STREAM;
          lead_d  = '0;
          slot_d  = '0;
        end else begin
          lead_d = lead_q + LW'(1);
        end
      end
      S_STREAM: begin
        if (slot_q == SLOT_SAMPLE) begin
          case (k_q)
            2'd0: asm_d[1:0] = sync2_q;
            2'd1: asm_d[3:2] = sync2_q;
            2'd2: asm_d[5:4] = sync2_q;
            default: begin
              // Fourth pair: hand the finished byte to the holding stage next edge.
              cmp_d     = 1'b1;
              cmpbyte_d = {sync2_q, asm_q};
              asm_d     = '0;
            end
          endcase
          k_d = k_q + 2'd1;
        end
        if (slot_q == SLOT_LAST) begin
          slot_d = '0;
          if (bits_q == BITS_LAST) begin
            state_d = S_TAIL;
            lead_d  = '0;
          end else begin
            bits_d = bits_q + PW'(1);
          end
        end else begin
          slot_d = slot_q + SW'(1);
        end
      end
      S_TAIL: begin
        if (lead_q == LEAD_LAST) begin
          state_d = S_IDLE;
          lead_d  = '0;
          done_d  = 1'b1;
        end else begin
          lead_d = lead_q + LW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // ABORT overrides everything, including a START seen in IDLE; any byte still
    // being assembled is thrown away.
    if (ABORT) begin
      state_d = S_IDLE;
      mode_d  = mode_q;
      clr_ovr = 1'b0;
      lead_d  = '0;
      slot_d  = '0;
      bits_d  = '0;
      k_d     = '0;
      asm_d   = '0;
      cmp_d   = 1'b0;
      done_d  = 1'b0;
    end
  end

  // Control outputs are decoded from the next state and registered, so they only
  // move on state transitions.
  always_comb begin
    active    = (state_d != S_IDLE);
    nbss_d    = !active;
    nbsen_d   = (state_d != S_STREAM);
    nrepen_d  = !(active && !mode_d);
    nbooten_d = !(active && mode_d);
    busy_d    = active;
  end

  // Holding register: a completed byte is loaded when the register is empty or
  // being accepted in the same cycle; otherwise it is dropped and flagged.
  always_comb begin
    byte_d  = byte_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (clr_ovr) begin
      ovr_d = 1'b0;
    end
    if (cmp_q) begin
      if (!valid_q || BYTEREADY) begin
        byte_d  = cmpbyte_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && BYTEREADY) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge MCLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q   <= S_IDLE;
      mode_q    <= 1'b0;
      lead_q    <= '0;
      slot_q    <= '0;
      bits_q    <= '0;
      k_q       <= '0;
      asm_q     <= '0;
      cmp_q     <= 1'b0;
      cmpbyte_q <= '0;
      sync1_q   <= '0;
      sync2_q   <= '0;
      nbss_q    <= 1'b1;
      nbsen_q   <= 1'b1;
      nrepen_q  <= 1'b1;
      nbooten_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      byte_q    <= '0;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      lead_q    <= lead_d;
      slot_q    <= slot_d;
      bits_q    <= bits_d;
      k_q       <= k_d;
      asm_q     <= asm_d;
      cmp_q     <= cmp_d;
      cmpbyte_q <= cmpbyte_d;
      sync1_q   <= {DOUT1, DOUT0};
      sync2_q   <= sync1_q;
      nbss_q    <= nbss_d;
      nbsen_q   <= nbsen_d;
      nrepen_q  <= nrepen_d;
      nbooten_q <= nbooten_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      byte_q    <= byte_d;
      valid_q   <= valid_d;
      ovr_q     <= ovr_d;
    end
  end

  assign nBSS      = nbss_q;
  assign nBSEN     = nbsen_q;
  assign nREPEN    = nrepen_q;
  assign nBOOTEN   = nbooten_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign BYTE      = byte_q;
  assign BYTEVALID = valid_q;
  assign OVERRUN   = ovr_q;

endmodule

// File: tb/tb_bubble_page_reader.sv
// tb_bubble_page_reader
//   Directed bench for bubble_page_reader using a shortened geometry:
//   8 cycles/slot, sample at 4, 32 slots/page (8 bytes), 6-cycle nBSS lead.
//   One page takes 6 + 256 + 6 cycles; DONE shows 268 cycles after the first SETUP cycle.
module tb_bubble_page_reader;

  localparam int BC   = 8;
  localparam int SP   = 4;
  localparam int PB   = 32;
  localparam int LEAD = 6;
  localparam int NBYTES = PB / 4;

  logic       MCLK = 1'b0;
  logic       nRESET = 1'b0;
  logic       START = 1'b0;
  logic       MODE = 1'b0;
  logic       ABORT = 1'b0;
  logic       DOUT0 = 1'b0;
  logic       DOUT1 = 1'b0;
  logic       BYTEREADY = 1'b1;
  logic       nBSS, nBSEN, nREPEN, nBOOTEN;
  logic [7:0] BYTE;
  logic       BYTEVALID, BUSY, DONE, OVERRUN;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  logic [7:0] rxq[$];

  bubble_page_reader #(
    .BITCYCLES  (BC),
    .SAMPLEPOINT(SP),
    .PAGEBITS   (PB),
    .BSS_LEAD   (LEAD)
  ) dut (
    .MCLK     (MCLK),
    .nRESET   (nRESET),
    .START    (START),
    .MODE     (MODE),
    .ABORT    (ABORT),
    .nBSS     (nBSS),
    .nBSEN    (nBSEN),
    .nREPEN   (nREPEN),
    .nBOOTEN  (nBOOTEN),
    .DOUT0    (DOUT0),
    .DOUT1    (DOUT1),
    .BYTE     (BYTE),
    .BYTEVALID(BYTEVALID),
    .BYTEREADY(BYTEREADY),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .OVERRUN  (OVERRUN)
  );

  always #5 MCLK = ~MCLK;

  // Records accepted bytes and DONE pulses, sampled mid-cycle.
  always begin
    @(negedge MCLK);
    #1;
    if (nRESET && BYTEVALID && BYTEREADY) rxq.push_back(BYTE);
    if (nRESET && DONE) done_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

  task automatic wait_for(input int sel, input logic lvl, input int limit, output bit ok);
    logic v;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      case (sel)
        0:       v = nBSEN;
        1:       v = DONE;
        default: v = BYTEVALID;
      endcase
      if (v === lvl) begin
        ok = 1'b1;
        break;
      end
      @(negedge MCLK);
    end
  endtask

  task automatic start_page(input logic m);
    @(negedge MCLK);
    START = 1'b1;
    MODE  = m;
    @(negedge MCLK);
    START = 1'b0;
  endtask

  task automatic test_reset;
    nRESET = 1'b0;
    repeat (3) @(negedge MCLK);
    n_checks++;
    if ({nBSS, nBSEN, nREPEN, nBOOTEN, BYTEVALID, BUSY, DONE, OVERRUN, BYTE} !== 16'hF000) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected %h",
               {nBSS, nBSEN, nREPEN, nBOOTEN, BYTEVALID, BUSY, DONE, OVERRUN, BYTE}, 16'hF000);
    end
    nRESET = 1'b1;
    repeat (2) @(negedge MCLK);
  endtask

  task automatic test_reset_mid_stream;
    bit ok;
    BYTEREADY = 1'b0;
    DOUT0 = 1'b1;
    DOUT1 = 1'b0;
    repeat (3) @(negedge MCLK);
    start_page(1'b0);
    wait_for(2, 1'b1, 400, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL rst_wait_byte: got timeout expected BYTEVALID=1");
    end
    repeat (10) @(negedge MCLK);
    nRESET = 1'b0;
    #1;
    n_checks++;
    if ({nBSS, nBSEN, nREPEN, nBOOTEN, BYTEVALID, BUSY, DONE, OVERRUN, BYTE} !== 16'hF000) begin
      n_fail++;
      $display("FAIL rst_mid_async: got %h expected %h",
               {nBSS, nBSEN, nREPEN, nBOOTEN, BYTEVALID, BUSY, DONE, OVERRUN, BYTE}, 16'hF000);
    end
    repeat (3) @(negedge MCLK);
    nRESET = 1'b1;
    BYTEREADY = 1'b1;
    repeat (5) @(negedge MCLK);
    n_checks++;
    if ({nBSS, nBSEN, BYTEVALID, BUSY, BYTE} !== 12'hC00) begin
      n_fail++;
      $display("FAIL rst_mid_idle: got %h expected %h", {nBSS, nBSEN, BYTEVALID, BUSY, BYTE}, 12'hC00);
    end
    rxq.delete();
  endtask

  task automatic test_normal_read;
    bit ok;
    int cnt;
    int d0;
    int bad;
    DOUT0 = 1'b1;
    DOUT1 = 1'b0;
    rxq.delete();
    d0 = done_cnt;
    start_page(1'b0);
    n_checks++;
    if ({nBSS, nBSEN, nREPEN, nBOOTEN, BUSY} !== 5'b01011) begin
      n_fail++;
      $display("FAIL norm_setup_ctrl: got %b expected %b", {nBSS, nBSEN, nREPEN, nBOOTEN, BUSY}, 5'b01011);
    end
    cnt = 0;
    while (nBSEN && cnt < 100) begin
      cnt++;
      @(negedge MCLK);
    end
    n_checks++;
    if (cnt != LEAD) begin
      n_fail++;
      $display("FAIL norm_bss_lead: got %0d expected %0d", cnt, LEAD);
    end
    wait_for(0, 1'b1, 400, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL norm_wait_tail: got timeout expected nBSEN=1");
    end
    cnt = 0;
    while (!DONE && cnt < 100) begin
      cnt++;
      @(negedge MCLK);
    end
    n_checks++;
    if (cnt != LEAD) begin
      n_fail++;
      $display("FAIL norm_done_delay: got %0d expected %0d", cnt, LEAD);
    end
    n_checks++;
    if ({nBSS, nBSEN, nREPEN, nBOOTEN, BUSY} !== 5'b11110) begin
      n_fail++;
      $display("FAIL norm_end_ctrl: got %b expected %b", {nBSS, nBSEN, nREPEN, nBOOTEN, BUSY}, 5'b11110);
    end
    repeat (5) @(negedge MCLK);
    n_checks++;
    if (done_cnt - d0 != 1) begin
      n_fail++;
      $display("FAIL norm_done_pulses: got %0d expected 1", done_cnt - d0);
    end
    n_checks++;
    if (rxq.size() != NBYTES) begin
      n_fail++;
      $display("FAIL norm_byte_count: got %0d expected %0d", rxq.size(), NBYTES);
    end
    bad = 0;
    foreach (rxq[i]) if (rxq[i] !== 8'h55) bad++;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL norm_byte_data: got %0d bytes not 55 expected 0", bad);
    end
  endtask

  task automatic test_bootloop_read;
    bit ok;
    int bad;
    DOUT0 = 1'b0;
    DOUT1 = 1'b0;
    rxq.delete();
    start_page(1'b1);
    n_checks++;
    if ({nBSS, nREPEN, nBOOTEN} !== 3'b010) begin
      n_fail++;
      $display("FAIL boot_ctrl: got %b expected %b", {nBSS, nREPEN, nBOOTEN}, 3'b010);
    end
    wait_for(0, 1'b0, 100, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL boot_wait_stream: got timeout expected nBSEN=0");
    end
    // Present slot index bits as the DOUT pair, one value per slot.
    for (int s = 0; s < PB; s++) begin
      DOUT0 = s[0];
      DOUT1 = s[1];
      repeat (BC) @(negedge MCLK);
    end
    wait_for(1, 1'b1, 100, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL boot_wait_done: got timeout expected DONE=1");
    end
    repeat (3) @(negedge MCLK);
    n_checks++;
    if (rxq.size() != NBYTES) begin
      n_fail++;
      $display("FAIL boot_byte_count: got %0d expected %0d", rxq.size(), NBYTES);
    end
    n_checks++;
    if (rxq.size() > 0 && rxq[0] !== 8'hE4) begin
      n_fail++;
      $display("FAIL boot_first_byte: got %h expected e4", rxq[0]);
    end
    bad = 0;
    foreach (rxq[i]) if (rxq[i] !== 8'hE4) bad++;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL boot_byte_data: got %0d bytes not e4 expected 0", bad);
    end
  endtask

  task automatic test_overrun;
    bit ok;
    DOUT0 = 1'b0;
    DOUT1 = 1'b1;
    BYTEREADY = 1'b0;
    rxq.delete();
    repeat (3) @(negedge MCLK);
    start_page(1'b0);
    wait_for(2, 1'b1, 400, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL ovr_wait_byte: got timeout expected BYTEVALID=1");
    end
    n_checks++;
    if ({BYTE, OVERRUN} !== {8'hAA, 1'b0}) begin
      n_fail++;
      $display("FAIL ovr_first_byte: got %h expected %h", {BYTE, OVERRUN}, {8'hAA, 1'b0});
    end
    wait_for(1, 1'b1, 400, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL ovr_wait_done: got timeout expected DONE=1");
    end
    n_checks++;
    if ({BYTE, BYTEVALID, OVERRUN} !== {8'hAA, 2'b11}) begin
      n_fail++;
      $display("FAIL ovr_held: got %h expected %h", {BYTE, BYTEVALID, OVERRUN}, {8'hAA, 2'b11});
    end
    BYTEREADY = 1'b1;
    repeat (2) @(negedge MCLK);
    n_checks++;
    if (BYTEVALID !== 1'b0 || rxq.size() != 1) begin
      n_fail++;
      $display("FAIL ovr_drain: got valid=%b count=%0d expected valid=0 count=1", BYTEVALID, rxq.size());
    end
  endtask

  task automatic test_abort;
    bit ok;
    int d0;
    DOUT0 = 1'b1;
    DOUT1 = 1'b0;
    rxq.delete();
    repeat (3) @(negedge MCLK);
    start_page(1'b0);
    n_checks++;
    if (OVERRUN !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_ovr_cleared: got %b expected 0", OVERRUN);
    end
    wait_for(0, 1'b0, 100, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL abort_wait_stream: got timeout expected nBSEN=0");
    end
    // Land mid-slot 13: bytes 0..2 complete, byte 3 partially assembled.
    repeat (13 * BC + 2) @(negedge MCLK);
    d0 = done_cnt;
    ABORT = 1'b1;
    @(negedge MCLK);
    ABORT = 1'b0;
    n_checks++;
    if ({nBSS, nBSEN, nREPEN, nBOOTEN, BUSY, DONE} !== 6'b111100) begin
      n_fail++;
      $display("FAIL abort_next_cycle: got %b expected %b", {nBSS, nBSEN, nREPEN, nBOOTEN, BUSY, DONE}, 6'b111100);
    end
    repeat (40) @(negedge MCLK);
    n_checks++;
    if (rxq.size() != 3 || done_cnt != d0 || BUSY !== 1'b0 || BYTEVALID !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_quiet: got bytes=%0d dones=%0d busy=%b valid=%b expected bytes=3 dones=0 busy=0 valid=0",
               rxq.size(), done_cnt - d0, BUSY, BYTEVALID);
    end
    START = 1'b1;
    ABORT = 1'b1;
    @(negedge MCLK);
    START = 1'b0;
    ABORT = 1'b0;
    @(negedge MCLK);
    n_checks++;
    if ({nBSS, BUSY} !== 2'b10) begin
      n_fail++;
      $display("FAIL abort_with_start: got %b expected %b", {nBSS, BUSY}, 2'b10);
    end
  endtask

  task automatic test_start_ignored;
    int cnt;
    int d0;
    int bad;
    DOUT0 = 1'b0;
    DOUT1 = 1'b1;
    rxq.delete();
    d0 = done_cnt;
    repeat (3) @(negedge MCLK);
    start_page(1'b0);
    cnt = 0;
    repeat (3) begin
      cnt++;
      @(negedge MCLK);
    end
    START = 1'b1;
    cnt++;
    @(negedge MCLK);
    START = 1'b0;
    repeat (50) begin
      cnt++;
      @(negedge MCLK);
    end
    START = 1'b1;
    cnt++;
    @(negedge MCLK);
    START = 1'b0;
    while (!DONE && cnt < 1000) begin
      cnt++;
      @(negedge MCLK);
    end
    n_checks++;
    if (cnt != 2 * LEAD + PB * BC) begin
      n_fail++;
      $display("FAIL ign_page_length: got %0d expected %0d", cnt, 2 * LEAD + PB * BC);
    end
    repeat (20) @(negedge MCLK);
    n_checks++;
    if (rxq.size() != NBYTES || done_cnt - d0 != 1 || BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL ign_single_page: got bytes=%0d dones=%0d busy=%b expected bytes=%0d dones=1 busy=0",
               rxq.size(), done_cnt - d0, BUSY, NBYTES);
    end
    bad = 0;
    foreach (rxq[i]) if (rxq[i] !== 8'hAA) bad++;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL ign_byte_data: got %0d bytes not aa expected 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_stream();
    test_normal_read();
    test_bootloop_read();
    test_overrun();
    test_abort();
    test_start_ignored();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
